player_input_ctrl: RTL and testbench
====================================

Name: player_input_ctrl

Overview:
- Converts debounced button levels (left, right, fire) into game commands for the player-ship logic.
- Movement buttons produce single-cycle move pulses, with a first-repeat delay and then auto-repeat.
- The fire button produces one shot request held until acknowledged, followed by a cooldown, so only one shot is outstanding at a time.
- Sits between the per-button debounce instances and the game core; single clock domain.

Parameters:
- CNT_W, 24, width of the shared timing counters.
- REPEAT_DELAY, 24'd5_000_000, cycles from the first move pulse to the first repeat pulse (must be >= 2).
- REPEAT_RATE, 24'd1_000_000, cycles between subsequent repeat pulses (must be >= 2).
- FIRE_COOLDOWN, 24'd10_000_000, cycles after fire_ack before a new fire request can be issued (must be >= 1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn_left  input  1  debounced left level, active high
- btn_right  input  1  debounced right level, active high
- btn_fire  input  1  debounced fire level, active high
- game_enable  input  1  high while gameplay is running
- fire_ack  input  1  game core accepted the shot (single-cycle or level)
- move_left  output  1  one-cycle move-left pulse
- move_right  output  1  one-cycle move-right pulse
- fire_req  output  1  shot request, held until acknowledged
- fire_busy  output  1  high in F_REQ, F_COOL and F_HOLD

Behaviour:
- Reset and clocking:
  - Clock is clk; reset is asynchronous, active-low (reset_n).
  - All outputs are registered and reset to 0; both FSMs reset to idle; counters and edge registers reset to 0.
- Edge detection: btn_*_d registers hold the previous samples. A rising edge is btn high while btn_d is low. Edge registers keep updating while game_enable is low.
- Direction resolution:
  - dir = LEFT if only btn_left is high; RIGHT if only btn_right is high; NONE if neither or both are high.
- Move FSM states: M_IDLE, M_FIRST, M_REPEAT.
  - M_IDLE: when dir != NONE and game_enable is high, pulse the matching move_* on the next cycle (latency 1 from the first high sample), clear the counter and go to M_FIRST.
  - M_FIRST: count cycles. Exactly REPEAT_DELAY cycles after the first pulse, pulse again and go to M_REPEAT with the counter cleared.
  - M_REPEAT: pulse every REPEAT_RATE cycles.
  - dir becomes NONE: return to M_IDLE next cycle with no pulse.
  - dir changes LEFT<->RIGHT: immediately pulse the new direction (latency 1), go to M_FIRST and clear the counter.
  - move_left and move_right are never high in the same cycle.
- Fire FSM states: F_IDLE, F_REQ, F_COOL, F_HOLD.
  - F_IDLE: a rising edge on btn_fire with game_enable high raises fire_req on the next cycle and enters F_REQ. A level held without an edge does not fire.
  - F_REQ: fire_req stays high until fire_ack is sampled high. fire_req drops on the following cycle, the counter clears and the FSM enters F_COOL.
  - fire_ack outside F_REQ is ignored.
  - F_COOL: after FIRE_COOLDOWN cycles, go to F_HOLD if btn_fire is still high, else to F_IDLE.
  - F_HOLD: wait for btn_fire low, then go to F_IDLE.
  - A new press during F_COOL is discarded, not queued.
- game_enable low (any state):
  - Both FSMs go to idle on the next cycle; fire_req and move_* drop; counters clear.
  - A button still held when game_enable rises needs a fresh rising edge for fire. Movement restarts from M_IDLE on the held level.
- Counters never wrap: they saturate at their terminal value, and all compares are equality on CNT_W bits.
- Simultaneous events: a move pulse and fire_req can coincide. Fire and move FSMs are fully independent.

Optional Feature:
- Macro AUTOFIRE_EN.
- Defined: at the end of F_COOL with btn_fire still high, go directly to F_REQ and raise fire_req on the next cycle; F_HOLD is unreachable.
- Not defined: behaviour as above; one shot per press.

Test Plan:
All scenarios use REPEAT_DELAY=8, REPEAT_RATE=4, FIRE_COOLDOWN=6, game_enable=1 unless stated.
- Hold btn_left high from cycle 0 to 19, then release -> move_left pulses at cycles 1, 9, 13 and 17 only; move_right stays 0.
- Hold btn_left high, then raise btn_right at cycle 5 -> no pulses while both are high. Drop btn_left at cycle 10 -> move_right pulses at 11 and 19.
- Fire rising edge at cycle 0, fire_ack at cycle 3 -> fire_req high in cycles 1-3, low from 4; fire_busy low at 10 if btn_fire was released, else F_HOLD until release.
- Without AUTOFIRE_EN, hold btn_fire for 30 cycles with fire_ack one cycle after each request -> exactly one fire_req. With AUTOFIRE_EN -> a new request after each cooldown.
- Deassert game_enable while in F_REQ and M_REPEAT -> fire_req and the move FSM are idle next cycle. Re-enable with fire still held -> no fire_req until a new press.
- Assert reset_n low mid-hold, asynchronously -> all outputs 0 immediately. After release with buttons low -> no pulses.

Source files
------------

// File: rtl/player_input_ctrl_if.sv
// Button/command bundle between the debounce stage, player_input_ctrl and the game core.
// slave: seen from player_input_ctrl. master: seen from the surrounding logic.
interface player_input_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic btn_fire;
  logic game_enable;
  logic fire_ack;
  logic move_left;
  logic move_right;
  logic fire_req;
  logic fire_busy;

  modport slave (
    input  btn_left, btn_right, btn_fire, game_enable, fire_ack,
    output move_left, move_right, fire_req, fire_busy
  );

  modport master (
    output btn_left, btn_right, btn_fire, game_enable, fire_ack,
    input  move_left, move_right, fire_req, fire_busy
  );
endinterface

// File: rtl/player_input_ctrl.sv
// Player input controller: turns debounced button levels into move pulses with auto-repeat
// and into a fire request/ack handshake with cooldown.
// Optional macro AUTOFIRE_EN: a held fire button re-fires at the end of every cooldown.
module player_input_ctrl #(
  parameter int unsigned      CNT_W         = 24,
  parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [CNT_W-1:0] REPEAT_RATE   = 24'd1_000_000,
  parameter logic [CNT_W-1:0] FIRE_COOLDOWN = 24'd10_000_000
) (
  input logic                clk,
  input logic                reset_n,
  player_input_ctrl_if.slave bus
);

  typedef enum logic [1:0] {DirNone, DirLeft, DirRight} dir_e;
  typedef enum logic [1:0] {MIdle, MFirst, MRepeat} move_state_e;
  typedef enum logic [1:0] {FIdle, FReq, FCool, FHold} fire_state_e;

  // Counters start at 0 in the cycle after the event, so the terminal count is N-1.
  localparam logic [CNT_W-1:0] DelayLast = REPEAT_DELAY - CNT_W'(1);
  localparam logic [CNT_W-1:0] RateLast  = REPEAT_RATE - CNT_W'(1);
  localparam logic [CNT_W-1:0] CoolLast  = FIRE_COOLDOWN - CNT_W'(1);

  move_state_e      move_state_q;
  dir_e             move_dir_q;
  logic [CNT_W-1:0] move_cnt_q;
  logic             move_left_q;
  logic             move_right_q;

  fire_state_e      fire_state_q;
  logic [CNT_W-1:0] fire_cnt_q;
  logic             fire_req_q;
  logic             fire_busy_q;
  logic             btn_fire_d;

  dir_e             dir;
  logic [CNT_W-1:0] move_last;
  logic             fire_rise;

  // Resolve the requested direction; both buttons pressed cancel each other.
  always_comb begin
    dir = DirNone;
    if (bus.btn_left && !bus.btn_right) begin
      dir = DirLeft;
    end else if (bus.btn_right && !bus.btn_left) begin
      dir = DirRight;
    end
  end

  assign move_last = (move_state_q == MFirst) ? DelayLast : RateLast;
  assign fire_rise = bus.btn_fire && !btn_fire_d;

  // Previous fire sample; keeps tracking while gameplay is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_fire_d <= 1'b0;
    end else begin
      btn_fire_d <= bus.btn_fire;
    end
  end

  // Move FSM: first pulse, delayed first repeat, then periodic repeats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      move_state_q <= MIdle;
      move_dir_q   <= DirNone;
      move_cnt_q   <= '0;
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
    end else begin
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      if (!bus.game_enable) begin
        move_state_q <= MIdle;
        move_dir_q   <= DirNone;
        move_cnt_q   <= '0;
      end else begin
        unique case (move_state_q)
          MIdle: begin
            if (dir != DirNone) begin
              move_left_q  <= (dir == DirLeft);
              move_right_q <= (dir == DirRight);
              move_dir_q   <= dir;
              move_cnt_q   <= '0;
              move_state_q <= MFirst;
            end
          end
          MFirst, MRepeat: begin
            if (dir == DirNone) begin
              move_state_q <= MIdle;
              move_dir_q   <= DirNone;
              move_cnt_q   <= '0;
            end else if (dir != move_dir_q) begin
              // Reversal restarts the repeat sequence in the new direction.
              move_left_q  <= (dir == DirLeft);
              move_right_q <= (dir == DirRight);
              move_dir_q   <= dir;
              move_cnt_q   <= '0;
              move_state_q <= MFirst;
            end else if (move_cnt_q == move_last) begin
              move_left_q  <= (dir == DirLeft);
              move_right_q <= (dir == DirRight);
              move_cnt_q   <= '0;
              move_state_q <= MRepeat;
            end else if (move_cnt_q != '1) begin
              move_cnt_q <= move_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            move_state_q <= MIdle;
            move_dir_q   <= DirNone;
            move_cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Fire FSM: one request per press, held until ack, then a cooldown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fire_state_q <= FIdle;
      fire_cnt_q   <= '0;
      fire_req_q   <= 1'b0;
      fire_busy_q  <= 1'b0;
    end else if (!bus.game_enable) begin
      fire_state_q <= FIdle;
      fire_cnt_q   <= '0;
      fire_req_q   <= 1'b0;
      fire_busy_q  <= 1'b0;
    end else begin
      unique case (fire_state_q)
        FIdle: begin
          if (fire_rise) begin
            fire_req_q   <= 1'b1;
            fire_busy_q  <= 1'b1;
            fire_state_q <= FReq;
          end
        end
        FReq: begin
          if (bus.fire_ack) begin
            fire_req_q   <= 1'b0;
            fire_cnt_q   <= '0;
            fire_state_q <= FCool;
          end
        end
        FCool: begin
          if (fire_cnt_q == CoolLast) begin
            fire_cnt_q <= '0;
            if (bus.btn_fire) begin
`ifdef AUTOFIRE_EN
              fire_req_q   <= 1'b1;
              fire_state_q <= FReq;
`else
              fire_state_q <= FHold;
`endif
            end else begin
              fire_busy_q  <= 1'b0;
              fire_state_q <= FIdle;
            end
          end else if (fire_cnt_q != '1) begin
            fire_cnt_q <= fire_cnt_q + CNT_W'(1);
          end
        end
        FHold: begin
          if (!bus.btn_fire) begin
            fire_busy_q  <= 1'b0;
            fire_state_q <= FIdle;
          end
        end
        default: begin
          fire_state_q <= FIdle;
          fire_req_q   <= 1'b0;
          fire_busy_q  <= 1'b0;
          fire_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.fire_req   = fire_req_q;
  assign bus.fire_busy  = fire_busy_q;

endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl with REPEAT_DELAY=8, REPEAT_RATE=4, FIRE_COOLDOWN=6.
// Cycle c starts at a rising edge; inputs change 1 ns after it, outputs are sampled on the
// falling edge of the same cycle.
module tb_player_input_ctrl;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  player_input_ctrl_if bus ();

  player_input_ctrl #(
    .CNT_W        (24),
    .REPEAT_DELAY (24'd8),
    .REPEAT_RATE  (24'd4),
    .FIRE_COOLDOWN(24'd6)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_fire  = 1'b0;
    bus.fire_ack  = 1'b0;
    bus.game_enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_fire = 1'b0;
    bus.fire_ack = 1'b0;
    bus.game_enable = 1'b1;
    #12;
    checks++;
    if (bus.move_left !== 1'b0) begin
      errors++; $display("FAIL reset move_left got %b want 0", bus.move_left);
    end
    checks++;
    if (bus.move_right !== 1'b0) begin
      errors++; $display("FAIL reset move_right got %b want 0", bus.move_right);
    end
    checks++;
    if (bus.fire_req !== 1'b0) begin
      errors++; $display("FAIL reset fire_req got %b want 0", bus.fire_req);
    end
    checks++;
    if (bus.fire_busy !== 1'b0) begin
      errors++; $display("FAIL reset fire_busy got %b want 0", bus.fire_busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
  endtask

  // Left held for cycles 0..19: pulses at 1, 9, 13, 17.
  task automatic test_hold_left();
    logic exp_l;
    for (int c = 0; c < 25; c++) begin
      bus.btn_left = (c <= 19);
      @(negedge clk);
      exp_l = (c == 1) || (c == 9) || (c == 13) || (c == 17);
      checks++;
      if (bus.move_left !== exp_l) begin
        errors++; $display("FAIL hold_left c=%0d move_left got %b want %b", c, bus.move_left, exp_l);
      end
      checks++;
      if (bus.move_right !== 1'b0) begin
        errors++; $display("FAIL hold_left c=%0d move_right got %b want 0", c, bus.move_right);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  // Both pressed cancels; releasing left starts right from idle.
  task automatic test_dir_conflict();
    logic exp_l;
    logic exp_r;
    for (int c = 0; c < 26; c++) begin
      bus.btn_left  = (c < 10);
      bus.btn_right = (c >= 5) && (c <= 20);
      @(negedge clk);
      exp_l = (c == 1);
      exp_r = (c == 11) || (c == 19);
      checks++;
      if (bus.move_left !== exp_l) begin
        errors++; $display("FAIL dir_conflict c=%0d move_left got %b want %b", c, bus.move_left, exp_l);
      end
      checks++;
      if (bus.move_right !== exp_r) begin
        errors++; $display("FAIL dir_conflict c=%0d move_right got %b want %b", c, bus.move_right, exp_r);
      end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  // Press at 0, released at 2, ack at 3: req 1..3, busy 1..9.
  task automatic test_fire_release();
    logic exp_req;
    logic exp_busy;
    for (int c = 0; c < 15; c++) begin
      bus.btn_fire = (c <= 1);
      bus.fire_ack = (c == 3);
      @(negedge clk);
      exp_req  = (c >= 1) && (c <= 3);
      exp_busy = (c >= 1) && (c <= 9);
      checks++;
      if (bus.fire_req !== exp_req) begin
        errors++; $display("FAIL fire_release c=%0d fire_req got %b want %b", c, bus.fire_req, exp_req);
      end
      checks++;
      if (bus.fire_busy !== exp_busy) begin
        errors++; $display("FAIL fire_release c=%0d fire_busy got %b want %b", c, bus.fire_busy, exp_busy);
      end
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  // Fire held for cycles 0..29, ack one cycle after each request would rise.
  task automatic test_fire_hold();
    logic exp_req;
    logic exp_busy;
    for (int c = 0; c < 36; c++) begin
      bus.btn_fire = (c <= 29);
      bus.fire_ack = (c == 2) || (c == 10) || (c == 18) || (c == 26);
      @(negedge clk);
`ifdef AUTOFIRE_EN
      exp_req  = (c == 1) || (c == 2) || (c == 9) || (c == 10) ||
                 (c == 17) || (c == 18) || (c == 25) || (c == 26);
      exp_busy = (c >= 1) && (c <= 32);
`else
      exp_req  = (c == 1) || (c == 2);
      exp_busy = (c >= 1) && (c <= 30);
`endif
      checks++;
      if (bus.fire_req !== exp_req) begin
        errors++; $display("FAIL fire_hold c=%0d fire_req got %b want %b", c, bus.fire_req, exp_req);
      end
      checks++;
      if (bus.fire_busy !== exp_busy) begin
        errors++; $display("FAIL fire_hold c=%0d fire_busy got %b want %b", c, bus.fire_busy, exp_busy);
      end
      @(posedge clk);
      #1;
    end
    idle(2);
  endtask

  // Disable in FReq + MRepeat, re-enable with buttons held, then a fresh fire press.
  task automatic test_enable_drop();
    logic exp_l;
    logic exp_req;
    logic exp_busy;
    for (int c = 0; c < 36; c++) begin
      bus.btn_left    = (c <= 30);
      bus.btn_fire    = (c <= 30) || (c >= 32);
      bus.game_enable = !((c >= 14) && (c <= 16));
      bus.fire_ack    = (c == 35);
      @(negedge clk);
      exp_l    = (c == 1) || (c == 9) || (c == 13) || (c == 18) || (c == 26) || (c == 30);
      exp_req  = ((c >= 1) && (c <= 14)) || (c >= 33);
      exp_busy = exp_req;
      checks++;
      if (bus.move_left !== exp_l) begin
        errors++; $display("FAIL enable_drop c=%0d move_left got %b want %b", c, bus.move_left, exp_l);
      end
      checks++;
      if (bus.fire_req !== exp_req) begin
        errors++; $display("FAIL enable_drop c=%0d fire_req got %b want %b", c, bus.fire_req, exp_req);
      end
      checks++;
      if (bus.fire_busy !== exp_busy) begin
        errors++; $display("FAIL enable_drop c=%0d fire_busy got %b want %b", c, bus.fire_busy, exp_busy);
      end
      @(posedge clk);
      #1;
    end
    idle(10);
  endtask

  // Reset mid-hold clears outputs without waiting for a clock edge.
  task automatic test_async_reset();
    logic exp_l;
    for (int c = 0; c < 10; c++) begin
      bus.btn_left = 1'b1;
      bus.btn_fire = 1'b1;
      @(negedge clk);
      exp_l = (c == 1) || (c == 9);
      checks++;
      if (bus.move_left !== exp_l) begin
        errors++; $display("FAIL async_reset pre c=%0d move_left got %b want %b", c, bus.move_left, exp_l);
      end
      checks++;
      if (bus.fire_req !== (c >= 1)) begin
        errors++; $display("FAIL async_reset pre c=%0d fire_req got %b want %b", c, bus.fire_req, (c >= 1));
      end
      if (c < 9) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.move_left, bus.move_right, bus.fire_req, bus.fire_busy} !== 4'b0000) begin
      errors++; $display("FAIL async_reset outputs got %b want 0000",
                         {bus.move_left, bus.move_right, bus.fire_req, bus.fire_busy});
    end
    bus.btn_left = 1'b0;
    bus.btn_fire = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.move_left, bus.move_right, bus.fire_req, bus.fire_busy} !== 4'b0000) begin
        errors++; $display("FAIL async_reset post c=%0d outputs got %b want 0000", c,
                           {bus.move_left, bus.move_right, bus.fire_req, bus.fire_busy});
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_hold_left();
    test_dir_conflict();
    test_fire_release();
    test_fire_hold();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
